// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between N_REQ requesters, the arbiter and the serial transmitter FIFO port.
// master = requesters plus the transmitter side as seen by the sources; slave = the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_full;
    logic               tx_wr_en;
    logic [7:0]         tx_din;
    logic [GW-1:0]      grant_id;
    logic               busy;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, tx_wr_en, tx_din, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, tx_wr_en, tx_din, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with burst lock sharing one transmitter FIFO write port among N_REQ sources.
// state   | meaning
// IDLE    | nobody owns the transmitter; pick next requester from rr_ptr (one cycle)
// GRANTED | grant_id owns the port; zero-latency handshake until last, MAX_BURST or stall timeout
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int MAX_BURST     = 16,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);
    localparam int GW = $clog2(N_REQ);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [GW-1:0]  rr_ptr, rr_ptr_n;
    logic [GW-1:0]  grant_id, grant_id_n;
    logic [7:0]     burst_cnt, burst_cnt_n;
    logic [15:0]    stall_cnt, stall_cnt_n;

    logic [GW-1:0]  rr_pick;
    logic           rr_found;
    logic [GW-1:0]  ptr_after_owner;
    logic           release_now;
    logic [N_REQ-1:0] req_ready;
    logic           tx_wr_en;
    logic [7:0]     tx_din;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        rr_pick  = '0;
        rr_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!rr_found && bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                rr_found = 1'b1;
                rr_pick  = GW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    assign ptr_after_owner = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + GW'(1);

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        grant_id_n  = grant_id;
        burst_cnt_n = burst_cnt;
        stall_cnt_n = stall_cnt;
        req_ready   = '0;
        tx_wr_en    = 1'b0;
        tx_din      = 8'h00;
        release_now = 1'b0;

        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_id_n  = rr_pick;
                    burst_cnt_n = '0;
                    stall_cnt_n = '0;
                    state_n     = GRANTED;
                end
            end
            GRANTED: begin
                req_ready[grant_id] = !bus.tx_full;
                tx_wr_en = bus.req_valid[grant_id] && !bus.tx_full;
                if (tx_wr_en) begin
                    tx_din      = bus.req_data[{grant_id, 3'b000} +: 8];
                    burst_cnt_n = burst_cnt + 8'd1;
                    stall_cnt_n = '0;
                    if (bus.req_last[grant_id] || ({1'b0, burst_cnt} + 9'd1 == 9'(MAX_BURST)))
                        release_now = 1'b1;
                end else if (!bus.tx_full) begin
                    // Backpressure does not count as a stall; only an idle owner does.
                    stall_cnt_n = stall_cnt + 16'd1;
                    if ({1'b0, stall_cnt} + 17'd1 == 17'(STALL_TIMEOUT))
                        release_now = 1'b1;
                end
                if (release_now) begin
                    state_n  = IDLE;
                    rr_ptr_n = ptr_after_owner;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            grant_id  <= grant_id_n;
            burst_cnt <= burst_cnt_n;
            stall_cnt <= stall_cnt_n;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.tx_wr_en  = tx_wr_en;
    assign bus.tx_din    = tx_din;
    assign bus.grant_id  = grant_id;
    assign bus.busy      = (state == GRANTED);

endmodule
